// File: rtl/demux_rr_sched.sv
// Round-robin 1:2 demux front-end: accepts upstream words with valid/ready and
// steers each accepted word to lane 0 or lane 1, counting deliveries per lane.
module demux_rr_sched #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   input  logic              mode,
   input  logic              ready0,
   input  logic              ready1,
   output logic [DATA_W-1:0] data_out0,
   output logic [DATA_W-1:0] data_out1,
   output logic              valid_out0,
   output logic              valid_out1,
   output logic              sel_out,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);

   typedef enum logic {S0 = 1'b0, S1 = 1'b1} state_t;

   state_t state, state_next;
   logic   cur_lane;
   logic   pref_ready;
   logic   target;
   logic   accept;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) state <= S0;
      else          state <= state_next;
   end

   // In skip mode a busy preferred lane hands the word to the other lane.
   always_comb begin
      state_next = state;
      cur_lane   = (state == S1);
      pref_ready = cur_lane ? ready1 : ready0;
      target     = cur_lane;
      ready_out  = 1'b0;
      if (mode) begin
         ready_out = ready0 | ready1;
         target    = pref_ready ? cur_lane : ~cur_lane;
      end else begin
         ready_out = pref_ready;
      end
      ready_out = ready_out & reset_L;
      accept    = valid_in & ready_out;
      if (accept) state_next = target ? S0 : S1;
   end

   assign sel_out = (state == S1);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         data_out0  <= '0;
         data_out1  <= '0;
         valid_out0 <= 1'b0;
         valid_out1 <= 1'b0;
         cnt0       <= '0;
         cnt1       <= '0;
      end else begin
         valid_out0 <= accept & ~target;
         valid_out1 <= accept & target;
         if (accept && !target) begin
            data_out0 <= data_in;
            cnt0      <= cnt0 + 1'b1;
         end
         if (accept && target) begin
            data_out1 <= data_in;
            cnt1      <= cnt1 + 1'b1;
         end
      end
   end

endmodule
